// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit port to a single-word synchronous memory
//
// Purpose: accepts one core load/store at a time and turns it into memory read
// and/or write strobes. Byte and half stores use read-modify-write. Loads are
// sign- or zero-extended.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to answer misaligned requests
// with resp_err=1 and no memory access. Without it, the low address bits are
// ignored for the access size and resp_err is always 0.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready only while idle)
//   req_we, req_size, req_unsigned store flag, 00 byte/01 half/1x word, zero-extend
//   req_addr, req_wdata            byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err   one-cycle completion, load result, misalign flag
//   mem_r_enable, mem_w_enable     registered memory strobes
//   mem_addr, mem_wdata, mem_rdata word index, write word, read word
module lsu_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_w_enable,
    output logic        mem_r_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        trap;
    logic [1:0]  lane_in;

    logic        we_q;
    logic [1:0]  size_q;     // normalised: 00 byte, 01 half, 10 word
    logic        uns_q;
    logic [1:0]  lane_q;     // byte offset of the accessed lane inside the word
    logic [15:0] wdata_q;    // only the low half is ever merged

    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;
    logic [31:0] load_ext;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign trap     = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
    assign resp_err = err_q;
`else
    assign trap     = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Lane offset with the bits below the access size dropped (align down).
    always_comb begin
        lane_in = 2'b00;
        case (req_size)
            2'b00:   lane_in = req_addr[1:0];
            2'b01:   lane_in = {req_addr[1], 1'b0};
            default: lane_in = 2'b00;
        endcase
    end

    always_comb begin
        shift     = {lane_q, 3'b000};
        lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << shift) : (32'h0000_FFFF << shift);
        lane_data = {16'h0000, wdata_q} << shift;
        merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
        load_ext  = mem_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & mem_rdata[shift + 5'd7]}}, mem_rdata[shift +: 8]};
            2'b01:   load_ext = {{16{~uns_q & mem_rdata[shift + 5'd15]}}, mem_rdata[shift +: 16]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (trap)                      state_next = RESP;
                    else if (req_we && req_size[1]) state_next = WRITE;
                    else                           state_next = READ;
                end
            end
            READ:    state_next = WAIT;
            // Memory data is on mem_rdata during WAIT; stores go on to merge and write.
            WAIT:    state_next = we_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            resp_rdata   <= 32'h0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // READ and WRITE each last exactly one cycle, so the strobes follow the state.
            mem_r_enable <= (state_next == READ);
            mem_w_enable <= (state_next == WRITE);
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size[1] ? 2'b10 : req_size;
                uns_q      <= req_unsigned;
                lane_q     <= lane_in;
                wdata_q    <= req_wdata[15:0];
                mem_addr   <= {2'b00, req_addr[31:2]};
                resp_rdata <= 32'h0;
                if (req_we) mem_wdata <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                err_q      <= trap;
`endif
            end
            if (state == WAIT) begin
                if (we_q) mem_wdata  <= merged;
                else      resp_rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port
module tb_lsu_mem_port;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_w_enable;
    logic        mem_r_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    lsu_mem_port dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Environment memory: synchronous read, synchronous write.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_w_enable) mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[3:0]];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:15];
    bit          busy = 1'b0;
    int          cyc, lat, kind;   // kind: 0 trap, 1 load, 2 word store, 3 sub-word store
    logic [31:0] e_rdata, e_merged, e_widx;
    logic        e_err, e_store;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input int sz, input logic uns);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        h = a[1] ? {b[3], b[2]} : {b[1], b[0]};
        if (sz == 0) return uns ? {24'h0, b[a]} : {{24{b[a][7]}}, b[a]};
        if (sz == 1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] a,
                                                input int sz, input logic [31:0] d);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (sz == 0) b[a] = d[7:0];
        else if (a[1]) begin b[3] = d[15:8]; b[2] = d[7:0]; end
        else begin b[1] = d[15:8]; b[0] = d[7:0]; end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    always @(negedge clk) begin
        int  sz;
        bit  mis;
        bit  exp_r, exp_w, exp_v;
        if (rst) begin
            busy = 1'b0;
            chk("rst_ready", {31'h0, req_ready}, 32'h0);
            chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_mem_r", {31'h0, mem_r_enable}, 32'h0);
            chk("rst_mem_w", {31'h0, mem_w_enable}, 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end else begin
            if (busy) begin
                cyc++;
                if (cyc > lat) busy = 1'b0;
            end else if (req_valid) begin
                sz      = (req_size == 2'd3) ? 2 : int'(req_size);
                mis     = (sz == 1 && req_addr[0]) || (sz == 2 && req_addr[1:0] != 2'b00);
                e_widx  = req_addr >> 2;
                e_err   = 1'b0;
                e_rdata = 32'h0;
                e_store = 1'b0;
                if (mis && TRAP) begin
                    kind = 0; lat = 0; e_err = 1'b1;
                end else if (!req_we) begin
                    kind = 1; lat = 2;
                    e_rdata = model_load(ref_mem[e_widx[3:0]], req_addr[1:0], sz, req_unsigned);
                end else if (sz == 2) begin
                    kind = 2; lat = 1; e_store = 1'b1; e_merged = req_wdata;
                end else begin
                    kind = 3; lat = 3; e_store = 1'b1;
                    e_merged = model_merge(ref_mem[e_widx[3:0]], req_addr[1:0], sz, req_wdata);
                end
                busy = 1'b1;
                cyc  = 0;
            end
            exp_r = busy && cyc == 0 && (kind == 1 || kind == 3);
            exp_w = busy && ((kind == 2 && cyc == 0) || (kind == 3 && cyc == 2));
            exp_v = busy && cyc == lat;
            chk("ready", {31'h0, req_ready}, {31'h0, !busy});
            chk("mem_r_enable", {31'h0, mem_r_enable}, {31'h0, exp_r});
            chk("mem_w_enable", {31'h0, mem_w_enable}, {31'h0, exp_w});
            chk("strobe_overlap", {31'h0, mem_r_enable & mem_w_enable}, 32'h0);
            if (exp_r || exp_w) chk("mem_addr", mem_addr, e_widx);
            if (exp_w) chk("mem_wdata", mem_wdata, e_merged);
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_v});
            if (exp_v) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e_err});
                if (e_store) ref_mem[e_widx[3:0]] = e_merged;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat_o, output logic [31:0] rd_o, output logic err_o);
        int n;
        @(negedge clk); #1;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 20) begin
            if (n == 0) #1 req_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        if (n >= 20) chk("resp_timeout", 32'h1, 32'h0);
        lat_o = n; rd_o = resp_rdata; err_o = resp_err;
        @(negedge clk);
    endtask

    initial begin
        int          l;
        logic [31:0] rd;
        logic        er;
        int          cnt;
        for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end

        repeat (3) @(negedge clk);
        chk("reset_ready_low", {31'h0, req_ready}, 32'h0);
        #1 rst = 1'b0;

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, l, rd, er);
        chk("wst_lat", l, 1);
        chk("wst_mem", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, l, rd, er);
        chk("wld_lat", l, 2);
        chk("wld_data", rd, 32'hDEADBEEF);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, l, rd, er);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, l, rd, er);
        chk("bst_lat", l, 3);
        chk("bst_mem", mem[4], 32'h1122AB44);
        chk("bst_rdata", rd, 32'h0);

        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, l, rd, er);
        chk("lb_signed", rd, 32'hFFFFFFAB);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, l, rd, er);
        chk("lb_unsigned", rd, 32'h000000AB);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, l, rd, er);
        chk("lh_hi_signed", rd, 32'h00001122);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, l, rd, er);
        chk("lh_lo_signed", rd, 32'hFFFFAB44);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, l, rd, er);
        chk("lh_lo_unsigned", rd, 32'h0000AB44);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, l, rd, er);
        chk("size11_word", rd, 32'h1122AB44);

        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, l, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lat", l, 0);
        chk("mis_err", {31'h0, er}, 32'h1);
        chk("mis_rdata", rd, 32'h0);
`else
        chk("mis_lat", l, 2);
        chk("mis_err", {31'h0, er}, 32'h0);
        chk("mis_rdata", rd, 32'h1122AB44);
`endif

        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008765, l, rd, er);
        chk("hst_lat", l, 3);
        chk("hst_mem", mem[4], 32'h8765AB44);

        // Reset while a half store sits in WAIT.
        @(negedge clk); #1;
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h5555; req_valid = 1'b1;
        @(negedge clk); #1 req_valid = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
        #1;
        chk("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("arst_mem_w", {31'h0, mem_w_enable}, 32'h0);
        chk("arst_mem_r", {31'h0, mem_r_enable}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_ready", {31'h0, req_ready}, 32'h0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("arst_mem_kept", mem[4], 32'h8765AB44);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, l, rd, er);
        chk("post_rst_lat", l, 2);
        chk("post_rst_data", rd, 32'h8765AB44);

        // req_valid held high: one accept per RESP->IDLE turn.
        @(negedge clk); #1;
        req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b1; req_addr = 32'h12;
        req_valid = 1'b1;
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (resp_valid) begin
                cnt++;
                chk("b2b_data", resp_rdata, 32'h00008765);
            end
        end
        #1 req_valid = 1'b0;
        chk("b2b_count", cnt, 4);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
